audio_mem_arbiter: RTL and testbench
====================================

// Module: audio_mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single audio chunk memory port among the record,
//  play and mix engines. Each requester asks for a burst of words at a chunk address;
//  the arbiter grants one requester, runs the burst word by word over a req/ack
//  memory handshake and signals burst completion. It sits between the engines and
//  the SRAM/SDRAM controller.
// PARAMETERS
//  NREQ    4   number of requesters (index 0 = record, 1 = play, 2..3 = mix)
//  ADDR_W  23  word address width (matches chunk select width)
//  DATA_W  16  audio sample width
//  LEN_W   8   burst length field width
// PORTS
//  i_clk        in   1             system clock
//  i_rst_n      in   1             synchronous reset, active low
//  i_req        in   NREQ          per-requester burst request, held until o_done
//  i_we         in   NREQ          1 = write burst, 0 = read burst
//  i_addr       in   NREQ*ADDR_W   burst start address, requester k in [k*ADDR_W +: ADDR_W]
//  i_len        in   NREQ*LEN_W    burst length in words (0 is treated as 1)
//  i_wdata      in   NREQ*DATA_W   write data, current word of each requester
//  o_gnt        out  NREQ          one-hot grant, held for the whole burst
//  o_wnext      out  NREQ          1-cycle pulse: write word accepted; present the next word
//  o_rvalid     out  NREQ          1-cycle pulse: o_rdata is valid for this requester
//  o_rdata      out  DATA_W        read data, shared bus
//  o_done       out  NREQ          1-cycle pulse: burst finished (normal or aborted)
//  o_mem_req    out  1             memory access request
//  o_mem_we     out  1             memory write enable
//  o_mem_addr   out  ADDR_W        memory word address
//  o_mem_wdata  out  DATA_W        memory write data
//  i_mem_ack    in   1             memory accepted the word (read data valid in the same cycle)
//  i_mem_rdata  in   DATA_W        memory read data
// BEHAVIOUR
//  - One clock, i_clk. Reset: i_rst_n sampled low at a rising edge clears every output,
//    the counters and the FSM to 0 / IDLE. The round-robin pointer resets to 0. Reset
//    mid-burst drops o_mem_req at the reset edge and emits no o_done.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: if any i_req is set, select the first set index searching upward from
//    last_winner+1 modulo NREQ. After reset the search starts at index 0.
//    On the same edge: latch the winner's address, length (0 -> 1), and the winner's
//    i_we. Set o_gnt[winner] and enter ACCESS.
//    Grant latency: 1 cycle from i_req to o_gnt.
//  - ACCESS: o_mem_req=1 and o_mem_addr = current address.
//    o_mem_we = latched we; o_mem_wdata = i_wdata[winner].
//    Hold these until i_mem_ack. On an ack:
//      - write burst: pulse o_wnext[winner];
//      - read burst: pulse o_rvalid[winner] with o_rdata = i_mem_rdata, registered,
//        so o_rvalid appears 1 cycle after the ack;
//      - address += 1, wrapping modulo 2^ADDR_W;
//      - count += 1.
//    An ack on the last word (count == len-1) goes to DONE.
//    o_mem_req deasserts the cycle after the final ack; it is never high in DONE or IDLE.
//  - Abort: if i_req[winner] falls during ACCESS, the outstanding word still completes
//    on its ack. The arbiter then goes to DONE and issues no further words.
//  - DONE: pulse o_done[winner] for 1 cycle, clear o_gnt, set last_winner = winner,
//    go to IDLE. A new grant is possible on the next cycle: minimum 1 idle cycle
//    between bursts.
//  - Requests arriving or changing during a burst are ignored until IDLE; no preemption.
//  - o_gnt, o_done, o_wnext and o_rvalid are each one-hot or zero. A requester's
//    i_addr, i_len and i_we are only sampled at grant.
// TESTING
//  1 Reset: hold i_rst_n=0 with i_req=4'b1111 -> all outputs 0 and no grant until
//    the first edge after release; the first grant is o_gnt=4'b0001.
//  2 Single read: req[1], addr=0x000100, len=4, ack every cycle -> mem_addr 0x100..0x103,
//    four o_rvalid[1] pulses carrying the data, o_done[1] 1 cycle after the last rvalid.
//  3 Round robin: i_req=4'b1111 held, len=1 -> grant order 0,1,2,3,0, one burst each.
//  4 Wrap and length 0: write burst at addr=0x7FFFFF, len=2 -> mem_addr 0x7FFFFF then
//    0x000000, two o_wnext pulses. A separate burst with len=0 performs exactly 1 access.
//  5 Abort/backpressure: len=8, ack every 3rd cycle, drop i_req after the 2nd ack -> 3rd
//    word completes, o_done pulses, then 0 further mem_req.
//  6 Reset mid-burst at word 3 -> o_mem_req=0 and o_gnt=0 at the reset edge; no o_done;
//    after release the pointer is 0 again.

Source files
------------

// File: rtl/audio_mem_arbiter.sv
// Round-robin arbiter that shares the audio chunk memory port between the
// record, play and mix engines, running word-by-word bursts over req/ack.
module audio_mem_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ-1:0]        i_we,
  input  logic [NREQ*ADDR_W-1:0] i_addr,
  input  logic [NREQ*LEN_W-1:0]  i_len,
  input  logic [NREQ*DATA_W-1:0] i_wdata,
  output logic [NREQ-1:0]        o_gnt,
  output logic [NREQ-1:0]        o_wnext,
  output logic [NREQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]      o_rdata,
  output logic [NREQ-1:0]        o_done,
  output logic                   o_mem_req,
  output logic                   o_mem_we,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [DATA_W-1:0]      o_mem_wdata,
  input  logic                   i_mem_ack,
  input  logic [DATA_W-1:0]      i_mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state;
  logic [IW-1:0]     win;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     pick;
  logic              found;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  last_cnt;
  logic [LEN_W-1:0]  len_in;
  int                idx;

  // ptr holds the index the upward search starts from (last winner + 1)
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign len_in     = i_len[int'(pick)*LEN_W +: LEN_W];
  assign o_mem_addr = addr;

  // write handshake is combinational so the engine swaps in its next
  // word on the ack edge and the port never rewrites a stale sample
  assign o_wnext = (state == ACCESS && i_mem_ack && o_mem_we)
                 ? o_gnt : '0;
  assign o_mem_wdata = o_mem_we
                     ? i_wdata[int'(win)*DATA_W +: DATA_W] : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      win       <= '0;
      ptr       <= '0;
      addr      <= '0;
      cnt       <= '0;
      last_cnt  <= '0;
      o_gnt     <= '0;
      o_rvalid  <= '0;
      o_rdata   <= '0;
      o_done    <= '0;
      o_mem_req <= 1'b0;
      o_mem_we  <= 1'b0;
    end else begin
      o_done   <= '0;
      o_rvalid <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            win       <= pick;
            addr      <= i_addr[int'(pick)*ADDR_W +: ADDR_W];
            last_cnt  <= (len_in == '0) ? '0 : len_in - LEN_W'(1);
            cnt       <= '0;
            o_gnt     <= NREQ'(1) << pick;
            o_mem_req <= 1'b1;
            o_mem_we  <= i_we[pick];
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (i_mem_ack) begin
            if (!o_mem_we) begin
              o_rvalid <= o_gnt;
              o_rdata  <= i_mem_rdata;
            end
            addr <= addr + ADDR_W'(1);
            cnt  <= cnt + LEN_W'(1);
            if (cnt == last_cnt || !i_req[win]) begin
              o_mem_req <= 1'b0;
              o_mem_we  <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          o_done <= o_gnt;
          o_gnt  <= '0;
          ptr    <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mem_arbiter.sv
// Directed self-checking bench for audio_mem_arbiter.
// Inputs change 2ns after a rising edge; outputs are checked there too.
module tb_audio_mem_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*LEN_W-1:0]  len;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        wnext;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic [NREQ-1:0]        done;
  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_ack;
  logic [DATA_W-1:0]      mem_rdata;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign mem_rdata = 16'hA000 ^ mem_addr[15:0];

  audio_mem_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_we(we),
    .i_addr(addr),
    .i_len(len),
    .i_wdata(wdata),
    .o_gnt(gnt),
    .o_wnext(wnext),
    .o_rvalid(rvalid),
    .o_rdata(rdata),
    .o_done(done),
    .o_mem_req(mem_req),
    .o_mem_we(mem_we),
    .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, nack, nrv, ndone, late, phase;
    logic dropped;
    logic [3:0] rr [5];
    rr[0] = 4'b0001; rr[1] = 4'b0010; rr[2] = 4'b0100;
    rr[3] = 4'b1000; rr[4] = 4'b0001;

    rst_n = 1'b0; req = 4'b1111; we = '0;
    addr = '0; len = '0; wdata = '0; mem_ack = 1'b0;

    // reset held with every requester asking
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wnext", wnext, 0);
    rst_n = 1'b1;
    tick();
    chk("first_gnt", gnt, 4'b0001);
    chk("first_mem_req", mem_req, 1);
    rst_n = 1'b0; req = '0;
    tick();
    rst_n = 1'b1;

    // single read burst on requester 1
    addr[1*ADDR_W +: ADDR_W] = 23'h000100;
    len[1*LEN_W +: LEN_W] = 8'd4;
    we = '0; mem_ack = 1'b1; req = 4'b0010;
    tick();
    chk("rd_gnt", gnt, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      chk("rd_mem_req", mem_req, 1);
      chk("rd_mem_addr", mem_addr, 64'h100 + k);
      chk("rd_mem_we", mem_we, 0);
      tick();
      chk("rd_rvalid", rvalid, 4'b0010);
      chk("rd_rdata", rdata, 64'hA100 + k);
    end
    chk("rd_req_low", mem_req, 0);
    chk("rd_done_early", done, 0);
    tick();
    chk("rd_done", done, 4'b0010);
    chk("rd_gnt_clr", gnt, 0);
    chk("rd_rvalid_clr", rvalid, 0);
    req = '0;

    // round robin from a fresh reset, len=1 each
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NREQ; k++) len[k*LEN_W +: LEN_W] = 8'd1;
    mem_ack = 1'b1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", gnt, rr[k]);
      tick();
      chk("rr_req_done_state", mem_req, 0);
      tick();
      chk("rr_done", done, rr[k]);
      if (k == 4) req = '0;
    end

    // write burst wrapping the top of the address space
    addr[2*ADDR_W +: ADDR_W] = 23'h7FFFFF;
    len[2*LEN_W +: LEN_W] = 8'd2;
    we = 4'b0100; wdata[2*DATA_W +: DATA_W] = 16'h1111;
    mem_ack = 1'b0; req = 4'b0100;
    tick();
    chk("wr_gnt", gnt, 4'b0100);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_addr0", mem_addr, 23'h7FFFFF);
    chk("wr_wdata0", mem_wdata, 16'h1111);
    chk("wr_wnext_noack", wnext, 0);
    mem_ack = 1'b1;
    #1;
    chk("wr_wnext0", wnext, 4'b0100);
    tick();
    wdata[2*DATA_W +: DATA_W] = 16'h2222;
    #1;
    chk("wr_addr1", mem_addr, 0);
    chk("wr_wdata1", mem_wdata, 16'h2222);
    chk("wr_wnext1", wnext, 4'b0100);
    tick();
    chk("wr_req_low", mem_req, 0);
    chk("wr_wnext_clr", wnext, 0);
    tick();
    chk("wr_done", done, 4'b0100);
    req = '0; we = '0;

    // zero-length burst still does one access
    addr[3*ADDR_W +: ADDR_W] = 23'h000050;
    len[3*LEN_W +: LEN_W] = 8'd0;
    mem_ack = 1'b1; req = 4'b1000;
    acc = 0; ndone = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_req) acc++;
      if (done[3]) begin
        ndone++;
        req = '0;
      end
    end
    chk("len0_accesses", acc, 1);
    chk("len0_done", ndone, 1);

    // abort under backpressure: ack every 3rd cycle
    addr[0 +: ADDR_W] = 23'h000200;
    len[0 +: LEN_W] = 8'd8;
    mem_ack = 1'b0; req = 4'b0001;
    tick();
    chk("ab_gnt", gnt, 4'b0001);
    nack = 0; nrv = 0; ndone = 0; late = 0;
    phase = 0; dropped = 1'b0;
    for (int c = 0; c < 40; c++) begin
      mem_ack = (phase % 3 == 2) && mem_req;
      if (mem_ack) nack++;
      tick();
      phase++;
      if (nack == 2 && !dropped) begin
        req = '0;
        dropped = 1'b1;
      end
      if (rvalid[0]) nrv++;
      if (ndone > 0 && mem_req) late++;
      if (done[0]) ndone++;
    end
    mem_ack = 1'b0;
    chk("ab_acks", nack, 3);
    chk("ab_rvalids", nrv, 3);
    chk("ab_done", ndone, 1);
    chk("ab_late_req", late, 0);

    // reset in the middle of a read burst
    addr[1*ADDR_W +: ADDR_W] = 23'h000300;
    len[1*LEN_W +: LEN_W] = 8'd8;
    mem_ack = 1'b1; req = 4'b0010;
    tick();
    tick(); tick(); tick();
    chk("mr_addr3", mem_addr, 23'h000303);
    chk("mr_req_pre", mem_req, 1);
    rst_n = 1'b0;
    tick();
    chk("mr_mem_req", mem_req, 0);
    chk("mr_gnt", gnt, 0);
    chk("mr_done", done, 0);
    tick();
    chk("mr_done_late", done, 0);
    rst_n = 1'b1; req = 4'b1010;
    tick();
    chk("mr_ptr_gnt", gnt, 4'b0010);
    req = '0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
